// File: rtl/lock_key_pkg.sv
// Shared types and helpers for the serial key loader.
// Purely declarative; no latency or backpressure of its own.
// Consumers import lock_key_pkg::* for the state enum and the parity helper.
package lock_key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        APPLIED,
        LOCKOUT
    } state_t;

    localparam int KEY_W_DEF     = 8;
    localparam int MAX_TRIES_DEF = 3;
    localparam int CNT_W_DEF     = 4;
    localparam int PAR_MAX_W     = 64;

    // Even-parity bit of a key zero-extended to PAR_MAX_W; the padding does not change the result.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/lock_key_shreg.sv
// Indexed key shift register: transfer k (k < KEY_W) writes bit k, transfer KEY_W captures parity.
// Latency: each bit lands at the accepting edge; done is combinational on the parity transfer.
// Backpressure: none of its own; shift_en is the upstream valid&ready handshake.
module lock_key_shreg
    import lock_key_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             ser_data,
    output logic [KEY_W-1:0] shreg,
    output logic             par,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KEY_W-1:0] shreg_q, shreg_d;
    logic             par_q, par_d;

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        done    = 1'b0;
        if (clr) begin
            cnt_d   = '0;
            shreg_d = '0;
            par_d   = 1'b0;
        end else if (shift_en) begin
            if (cnt_q == CNT_W'(KEY_W)) begin
                par_d = ser_data;
                done  = 1'b1;
                cnt_d = '0;
            end else begin
                for (int i = 0; i < KEY_W; i++) begin
                    if (cnt_q == CNT_W'(i)) shreg_d[i] = ser_data;
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
        end
    end

    assign shreg = shreg_q;
    assign par   = par_q;

endmodule

// File: rtl/lock_key_loader.sv
// Serial key loader: parity-checked key delivery to a MUX-locked netlist, sticky lockout after MAX_TRIES failures.
// Latency: key_valid/err update one edge after the parity handshake; full load is KEY_W+2 edges with no stalls.
// Backpressure: ser_ready only in SHIFT; ser_valid low stalls indefinitely, start ignored while busy or locked.
module lock_key_loader
    import lock_key_pkg::*;
#(
    parameter int KEY_W     = KEY_W_DEF,
    parameter int MAX_TRIES = MAX_TRIES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ser_valid,
    input  logic             ser_data,
    output logic             ser_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             err,
    output logic             lockout,
    output logic [CNT_W-1:0] attempts
);

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_out_q, key_out_d;
    logic             key_valid_q, key_valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] attempts_q, attempts_d;
    logic [CNT_W-1:0] attempts_inc;

    logic             load_clr;
    logic             shift_en;
    logic [KEY_W-1:0] shreg;
    logic             par;
    logic             done;

    assign shift_en = ser_valid && (state_q == SHIFT);

    lock_key_shreg #(
        .KEY_W (KEY_W),
        .CNT_W (CNT_W)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .clr      (load_clr),
        .shift_en (shift_en),
        .ser_data (ser_data),
        .shreg    (shreg),
        .par      (par),
        .done     (done)
    );

    assign attempts_inc = (attempts_q >= CNT_W'(MAX_TRIES)) ? attempts_q : attempts_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        key_out_d   = key_out_q;
        key_valid_d = key_valid_q;
        attempts_d  = attempts_q;
        err_d       = 1'b0;
        load_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_clr = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (done) state_d = CHECK;
            end
            CHECK: begin
                if (even_parity(PAR_MAX_W'(shreg)) == par) begin
                    key_out_d   = shreg;
                    key_valid_d = 1'b1;
                    attempts_d  = '0;
                    state_d     = APPLIED;
                end else begin
                    err_d      = 1'b1;
                    attempts_d = attempts_inc;
                    state_d    = (attempts_inc >= CNT_W'(MAX_TRIES)) ? LOCKOUT : IDLE;
                end
            end
            APPLIED: begin
                // Old key is withdrawn at the same edge the reload begins, so no mixed key is ever driven.
                if (start) begin
                    key_out_d   = '0;
                    key_valid_d = 1'b0;
                    load_clr    = 1'b1;
                    state_d     = SHIFT;
                end
            end
            LOCKOUT: begin
                state_d = LOCKOUT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            key_out_q   <= '0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            attempts_q  <= '0;
        end else begin
            state_q     <= state_d;
            key_out_q   <= key_out_d;
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
            attempts_q  <= attempts_d;
        end
    end

    assign ser_ready = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT) || (state_q == CHECK);
    assign lockout   = (state_q == LOCKOUT);
    assign key_out   = key_out_q;
    assign key_valid = key_valid_q;
    assign err       = err_q;
    assign attempts  = attempts_q;

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed plus randomized bench for lock_key_loader against a transaction-level outcome model.
module tb_lock_key_loader;

    localparam int KEY_W     = 8;
    localparam int MAX_TRIES = 3;
    localparam int CNT_W     = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             ser_valid;
    logic             ser_data;
    logic             ser_ready;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             busy;
    logic             err;
    logic             lockout;
    logic [CNT_W-1:0] attempts;

    int checks = 0;
    int errors = 0;

    // Expected architectural outcome, updated once per completed load.
    logic [KEY_W-1:0] m_key;
    logic             m_valid;
    int               m_att;
    logic             m_lock;

    lock_key_loader #(
        .KEY_W     (KEY_W),
        .MAX_TRIES (MAX_TRIES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_ready (ser_ready),
        .key_out   (key_out),
        .key_valid (key_valid),
        .busy      (busy),
        .err       (err),
        .lockout   (lockout),
        .attempts  (attempts)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_key_out"},   32'(key_out),   32'(m_key));
        chk({tag, "_key_valid"}, 32'(key_valid), 32'(m_valid));
        chk({tag, "_attempts"},  32'(attempts),  32'(m_att));
        chk({tag, "_lockout"},   32'(lockout),   32'(m_lock));
    endtask

    // Entered just after a negedge; drives rst for one edge, optionally together with start.
    task automatic do_reset(input logic with_start);
        rst       = 1'b1;
        start     = with_start;
        ser_valid = 1'($urandom_range(0, 1));
        ser_data  = 1'($urandom_range(0, 1));
        @(negedge clk);
        rst       = 1'b0;
        start     = 1'b0;
        ser_valid = 1'b0;
        m_key     = '0;
        m_valid   = 1'b0;
        m_att     = 0;
        m_lock    = 1'b0;
        check_outs("rst");
        chk("rst_ser_ready", 32'(ser_ready), 0);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_err",       32'(err),       0);
    endtask

    // mode 0: ser_valid held high; 1: toggles 1/0; 2: random. exp_edges 0 skips the timing checks.
    task automatic load(input logic [KEY_W-1:0] key, input logic par, input int mode,
                        input logic noise, input int exp_edges);
        logic [KEY_W:0] bits;
        int             idx;
        int             cyc;
        int             busy_cnt;
        logic           pass;
        bits      = {par, key};
        idx       = 0;
        cyc       = 0;
        busy_cnt  = 0;
        start     = 1'b1;
        ser_valid = 1'b0;
        @(negedge clk);
        start   = 1'b0;
        m_key   = '0;
        m_valid = 1'b0;
        chk("ld_start_key_out",   32'(key_out),   0);
        chk("ld_start_key_valid", 32'(key_valid), 0);
        chk("ld_start_ready",     32'(ser_ready), 1);
        while (idx <= KEY_W && cyc < 200) begin
            case (mode)
                0:       ser_valid = 1'b1;
                1:       ser_valid = (cyc % 2 == 0);
                default: ser_valid = 1'($urandom_range(0, 1));
            endcase
            ser_data = bits[idx[3:0]];
            start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (busy) busy_cnt++;
            if (ser_valid && ser_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        chk("ld_all_bits_taken", 32'(idx), KEY_W + 1);
        ser_valid = 1'b0;
        start     = noise;
        chk("chk_ser_ready", 32'(ser_ready), 0);
        chk("chk_busy",      32'(busy),      1);
        chk("chk_key_valid", 32'(key_valid), 0);
        if (busy) busy_cnt++;
        @(negedge clk);
        start = 1'b0;
        pass  = (($countones(key) + int'(par)) % 2) == 0;
        if (pass) begin
            m_key   = key;
            m_valid = 1'b1;
            m_att   = 0;
        end else begin
            if (m_att < MAX_TRIES) m_att++;
            m_lock = (m_att == MAX_TRIES);
        end
        chk("ld_err", 32'(err), 32'(!pass));
        check_outs("ld_done");
        chk("ld_done_busy", 32'(busy), 0);
        if (exp_edges > 0) begin
            chk("ld_edges",       32'(cyc + 1),  32'(exp_edges));
            chk("ld_busy_cycles", 32'(busy_cnt), 32'(exp_edges));
        end
        @(negedge clk);
        chk("ld_err_one_cycle", 32'(err),       0);
        chk("ld_idle_ready",    32'(ser_ready), 0);
        check_outs("ld_after");
    endtask

    task automatic locked_attempt();
        int ready_seen;
        ready_seen = 0;
        start      = 1'b1;
        ser_valid  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ser_data = 1'($urandom_range(0, 1));
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            if (ser_ready) ready_seen++;
        end
        start     = 1'b0;
        ser_valid = 1'b0;
        chk("lock_ready_seen", 32'(ready_seen), 0);
        chk("lock_busy",       32'(busy),       0);
        check_outs("lock");
    endtask

    // Starts a load, feeds nbits, then resets mid-load with start also asserted.
    task automatic partial_then_reset(input logic [KEY_W-1:0] key, input int nbits);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("reload_key_out",   32'(key_out),   0);
        chk("reload_key_valid", 32'(key_valid), 0);
        for (int i = 0; i < nbits; i++) begin
            ser_valid = 1'b1;
            ser_data  = key[i];
            @(negedge clk);
        end
        ser_valid = 1'b0;
        chk("partial_busy", 32'(busy), 1);
        do_reset(1'b1);
    endtask

    initial begin
        logic [KEY_W-1:0] rkey;
        logic             rpar;
        int               rmode;
        rst       = 1'b1;
        start     = 1'b0;
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        m_key     = '0;
        m_valid   = 1'b0;
        m_att     = 0;
        m_lock    = 1'b0;
        @(negedge clk);
        do_reset(1'b0);

        load(8'hA5, 1'b0, 0, 1'b0, KEY_W + 2);
        load(8'h07, 1'b1, 1, 1'b0, 2 * (KEY_W + 1));
        load(8'h07, 1'b0, 0, 1'b0, KEY_W + 2);
        load(8'h3C, 1'b0, 0, 1'b0, KEY_W + 2);

        for (int i = 0; i < MAX_TRIES; i++) begin
            rkey = KEY_W'($urandom);
            load(rkey, ~(^rkey), 0, 1'b0, KEY_W + 2);
        end
        chk("lockout_reached", 32'(lockout), 1);
        locked_attempt();
        do_reset(1'b0);

        load(8'hA5, 1'b0, 0, 1'b0, KEY_W + 2);
        partial_then_reset(8'h5A, 4);
        load(8'h5A, 1'b0, 0, 1'b0, KEY_W + 2);
        load(8'hC3, 1'b0, 0, 1'b1, KEY_W + 2);

        for (int i = 0; i < 25; i++) begin
            rkey  = KEY_W'($urandom);
            rpar  = ($urandom_range(0, 3) == 0) ? ~(^rkey) : (^rkey);
            rmode = int'($urandom_range(0, 2));
            load(rkey, rpar, rmode, 1'b1, (rmode == 0) ? KEY_W + 2 : 0);
            if (m_lock) begin
                locked_attempt();
                do_reset(1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_key_loader.md
Name: lock_key_loader

Overview:
Serial key loader for the MUX-based logic-locked netlists. It is the provisioning end of the key-input interface: it accepts key bits one per handshake from secure storage and checks an even-parity bit. Only on a passing check does it drive the locked netlist's key inputs (D_0..D_{KEY_W-1}) and assert key_valid. Repeated parity failures latch a sticky lockout.

Parameters:
KEY_W, 8, number of key bits (two per inserted key MUX); must be ≥2 and even.
MAX_TRIES, 3, consecutive failed loads before sticky lockout; must be ≥1.
CNT_W, 4, width of bit and attempt counters; must satisfy 2**CNT_W > max(KEY_W, MAX_TRIES).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  request a (re)load; 1-cycle pulse or level
ser_valid  in  1  source presents ser_data
ser_data  in  1  key bit, LSB first; bit KEY_W is the parity bit
ser_ready  out  1  loader accepts a bit this cycle
key_out  out  KEY_W  key to locked netlist; bit i drives D_i
key_valid  out  1  key_out holds a checked key
busy  out  1  load in progress (SHIFT or CHECK)
err  out  1  one-cycle pulse on parity failure
lockout  out  1  sticky; cleared only by rst
attempts  out  CNT_W  consecutive failed loads since last success or reset

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; key_out=0; key_valid=0; ser_ready=0; busy=0; err=0; lockout=0; attempts=0; shift register and bit counter=0. Reset mid-load abandons the load and takes no partial key.
- State IDLE: ser_ready=0. start=1 → SHIFT, bit counter=0.
- State SHIFT: ser_ready=1, busy=1.
  - A transfer occurs on an edge with ser_valid&ser_ready.
  - Transfer k (k=0..KEY_W-1) writes shreg[k]=ser_data.
  - Transfer KEY_W captures the parity bit → CHECK.
  - ser_valid=0 stalls the loader indefinitely; there is no timeout.
  - start is ignored in SHIFT.
- State CHECK: one cycle; ser_ready=0, busy=1. Pass when (^shreg) == parity bit, i.e. total ones are even.
  - Pass: at the CHECK edge, key_out=shreg, key_valid=1, attempts=0 → APPLIED.
  - Fail: err=1 for exactly one cycle (the cycle after the CHECK edge), attempts+=1, key_out and key_valid stay 0.
    - If the new attempts == MAX_TRIES → LOCKOUT.
    - Otherwise → IDLE.
- Latency: if the parity handshake happens at edge E, CHECK occupies the cycle after E and key_valid/err update at edge E+1. A full load takes KEY_W+2 edges from the start edge with ser_valid held high.
- State APPLIED: key_out stable, key_valid=1, ser_ready=0. start=1 → key_out=0, key_valid=0, SHIFT at the same edge. The netlist never sees a mix of old and new keys.
- State LOCKOUT: lockout=1, key_out=0, key_valid=0, ser_ready=0, busy=0. start is ignored. Only rst exits.
- Simultaneous start and rst: rst wins.
- attempts saturates at MAX_TRIES and never wraps.
- key_out and key_valid are registered outputs with no combinational path from inputs.

Decomposition:
- Package lock_key_pkg holds:
  - state enum {IDLE, SHIFT, CHECK, APPLIED, LOCKOUT};
  - default KEY_W and MAX_TRIES constants;
  - a function computing even parity over a KEY_W vector.
- One sub-module, lock_key_shreg: indexed shift register plus bit counter with a done flag at transfer KEY_W. The FSM, attempt counter and output registers stay in lock_key_loader.

Test Plan:
- Good load: rst, start, stream 0xA5 LSB first (1,0,1,0,0,1,0,1) then parity 0, ser_valid held high → key_out=8'hA5 and key_valid=1 at edge E+1; busy high for exactly 10 cycles; attempts=0.
- Stalled source: key 0x07 with parity 1, ser_valid toggled 1/0 each cycle → key_out=8'h07; no bit dropped or duplicated; load completes in 18 edges.
- Parity failure: key 0x07 with parity 0 → err pulses 1 cycle, attempts=1, key_valid=0, state IDLE; a following good load of 0x3C with parity 0 → key_out=8'h3C, attempts=0.
- Lockout: three consecutive bad loads → lockout=1 after the third; a following start plus a valid stream leaves ser_ready=0 and key_out=0; rst clears lockout=0 and attempts=0.
- Reload and reset mid-load: from APPLIED with 0xA5, start → key_valid=0 and key_out=0 at the same edge; after 4 bits, rst → all outputs at reset values; a fresh load of 0x5A with parity 0 succeeds.
- start asserted during SHIFT and CHECK → ignored; the load in flight completes normally.
